// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit: condition encodings,
// flag bit positions and the meaning of the decoder's flag-write bits.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Pure combinational condition evaluator: 4-bit condition field against the
// stored {N,Z,C,V} flags. Kept stateless so a fetch/branch stage can reuse it.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    cond_ex = 1'b0;
    case (cond_e'(cond))
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c & !z;
      COND_LS: cond_ex = !c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      // The 1111 encoding never executes in this core.
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Architectural NZCV flag register, condition gating of write/PC controls and
// a saturating debug count of retired instructions whose condition failed.
module cond_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_w,
  input  logic             no_write,
  input  logic             pc_s,
  input  logic             reg_w,
  input  logic             mem_w,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic             carry,
  output logic [3:0]       flags,
  output logic             cond_ex,
  output logic [CNT_W-1:0] skip_count
);

  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] skip_q, skip_d;

  // Evaluated against the stored flags so an instruction sees pre-update state.
  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  always_comb begin
    flags_d = flags_q;
    if (en && cond_ex) begin
      if (flag_w[FW_NZ]) flags_d[FLAG_N:FLAG_Z] = alu_flags[FLAG_N:FLAG_Z];
      if (flag_w[FW_CV]) flags_d[FLAG_C:FLAG_V] = alu_flags[FLAG_C:FLAG_V];
    end
  end

  always_comb begin
    skip_d = skip_q;
    if (en && !cond_ex && (skip_q != {CNT_W{1'b1}})) skip_d = skip_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= 4'b0000;
      skip_q  <= '0;
    end else begin
      flags_q <= flags_d;
      skip_q  <= skip_d;
    end
  end

  assign pc_src     = pc_s & cond_ex;
  assign reg_write  = reg_w & cond_ex & !no_write;
  assign mem_write  = mem_w & cond_ex;
  assign carry      = flags_q[FLAG_C];
  assign flags      = flags_q;
  assign skip_count = skip_q;

endmodule

// File: tb/tb_cond_unit.sv
// Directed and randomized bench for cond_unit, with a behavioural flag/count model.
module tb_cond_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [3:0]  cond;
  logic [3:0]  alu_flags;
  logic [1:0]  flag_w;
  logic        no_write, pc_s, reg_w, mem_w;
  logic        pc_src, reg_write, mem_write, carry, cond_ex;
  logic [3:0]  flags;
  logic [15:0] skip_count;
  logic        pc_src2, reg_write2, mem_write2, carry2, cond_ex2;
  logic [3:0]  flags2;
  logic [1:0]  skip_count2;

  int tests = 0;
  int fails = 0;

  logic [3:0] m_flags;
  int         m_skip;
  int         m_skip2;

  always #5 clk = ~clk;

  cond_unit #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .cond(cond), .alu_flags(alu_flags),
    .flag_w(flag_w), .no_write(no_write), .pc_s(pc_s), .reg_w(reg_w), .mem_w(mem_w),
    .pc_src(pc_src), .reg_write(reg_write), .mem_write(mem_write), .carry(carry),
    .flags(flags), .cond_ex(cond_ex), .skip_count(skip_count)
  );

  cond_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .en(en), .cond(cond), .alu_flags(alu_flags),
    .flag_w(flag_w), .no_write(no_write), .pc_s(pc_s), .reg_w(reg_w), .mem_w(mem_w),
    .pc_src(pc_src2), .reg_write(reg_write2), .mem_write(mem_write2), .carry(carry2),
    .flags(flags2), .cond_ex(cond_ex2), .skip_count(skip_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ARM semantics: pairs of encodings share a predicate, the odd one inverts it.
  function automatic bit model_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  task automatic model_reset();
    m_flags = 4'b0000;
    m_skip  = 0;
    m_skip2 = 0;
  endtask

  task automatic apply(input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                       input logic nw, input logic ps, input logic rw, input logic mw,
                       input logic e);
    bit ce;
    cond = c; alu_flags = af; flag_w = fw; no_write = nw;
    pc_s = ps; reg_w = rw; mem_w = mw; en = e;
    #1;
    ce = model_pass(c, m_flags);
    check("cond_ex", cond_ex, ce);
    check("pc_src", pc_src, ps & ce);
    check("reg_write", reg_write, rw & ce & !nw);
    check("mem_write", mem_write, mw & ce);
    if (e && ce) begin
      if (fw[1]) m_flags[3:2] = af[3:2];
      if (fw[0]) m_flags[1:0] = af[1:0];
    end
    if (e && !ce) begin
      if (m_skip < 65535) m_skip++;
      if (m_skip2 < 3) m_skip2++;
    end
    @(posedge clk);
    #1;
    check("flags", flags, m_flags);
    check("carry", carry, m_flags[1]);
    check("skip_count", skip_count, m_skip);
    check("skip_count_w2", skip_count2, m_skip2);
  endtask

  initial begin
    reset_n = 1'b0; en = 0; cond = 4'b0000; alu_flags = 0; flag_w = 0;
    no_write = 0; pc_s = 0; reg_w = 0; mem_w = 0;
    model_reset();
    #12;
    check("rst_flags", flags, 4'b0000);
    check("rst_carry", carry, 1'b0);
    check("rst_skip", skip_count, 16'd0);
    check("rst_cond_ex_eq", cond_ex, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // AL executes, EQ fails with Z=0
    apply(4'b1110, 4'b0000, 2'b00, 0, 0, 1, 0, 1);
    apply(4'b0000, 4'b0000, 2'b00, 0, 0, 1, 0, 1);
    check("skip_after_eq", skip_count, 16'd1);
    // Full flag write, then EQ and HI
    apply(4'b1110, 4'b0110, 2'b11, 0, 0, 0, 0, 1);
    check("flags_0110", flags, 4'b0110);
    apply(4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
    apply(4'b1000, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
    // NZ-only write keeps C,V
    apply(4'b1110, 4'b1001, 2'b10, 0, 0, 0, 0, 1);
    check("flags_1010", flags, 4'b1010);
    apply(4'b1011, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
    apply(4'b1010, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
    // CMP path
    apply(4'b1110, 4'b0100, 2'b11, 1, 0, 1, 0, 1);
    check("flags_cmp", flags, 4'b0100);
    apply(4'b0001, 4'b1111, 2'b11, 1, 0, 1, 0, 1);
    // en low: nothing moves
    for (int i = 0; i < 5; i++) apply(4'b0001, 4'b1111, 2'b11, 0, 1, 1, 1, 0);
    // NV never executes
    apply(4'b1111, 4'b1111, 2'b11, 0, 1, 1, 1, 1);

    // Saturation of the 2-bit counter from a fresh reset
    @(negedge clk); reset_n = 1'b0; model_reset();
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 5; i++) apply(4'b0000, 4'b0000, 2'b11, 0, 0, 0, 0, 1);
    check("skip_w2_sat", skip_count2, 2'd3);

    // Async reset between edges discards a pending write
    apply(4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0, 1);
    check("flags_1111", flags, 4'b1111);
    cond = 4'b1110; alu_flags = 4'b1111; flag_w = 2'b11; en = 1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_flags", flags, 4'b0000);
    check("async_carry", carry, 1'b0);
    check("async_skip", skip_count, 16'd0);
    @(posedge clk); #1;
    check("held_flags", flags, 4'b0000);
    @(negedge clk); reset_n = 1'b1;

    // Randomized retires
    for (int i = 0; i < 300; i++) begin
      apply(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
